// File: rtl/data_sram_resp_pkg.sv
// data_sram_resp_pkg: shared state encoding and constants for the data-SRAM responder
package data_sram_resp_pkg;
  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_e;
  localparam int DWORD_BYTES = 8;
  localparam logic [63:0] DEFAULT_BASE_ADDR = 64'h8000_0000;
endpackage

// File: rtl/data_sram_resp_if.sv
// data_sram_resp_if: EX-stage data-SRAM request/response bundle
interface data_sram_resp_if;
  logic        data_sram_en;
  logic [7:0]  data_sram_we;
  logic [63:0] data_sram_addr;
  logic [63:0] data_sram_wdata;
  logic [63:0] data_sram_rdata;
  logic        stallreq;
  logic        addr_err;
  modport master (
    output data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
    input  data_sram_rdata, stallreq, addr_err
  );
  modport slave (
    input  data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata,
    output data_sram_rdata, stallreq, addr_err
  );
endinterface

// File: rtl/data_sram_resp_sram_be_64.sv
// sram_be_64: single-port 64-bit RAM, byte write enables, registered read on we == 0
module sram_be_64
  import data_sram_resp_pkg::*;
#(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          en_i,
  input  logic [7:0]    we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [63:0]   wdata_i,
  output logic [63:0]   rdata_o
);
  logic [63:0] mem_q [2**AW];
  logic [63:0] rdata_q;
  always_ff @(posedge clk) begin
    if (en_i) begin
      for (int i = 0; i < DWORD_BYTES; i++)
        if (we_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      if (we_i == '0) rdata_q <= mem_q[addr_i];
    end
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/data_sram_resp.sv
// data_sram_resp: data-SRAM responder with wait states, registered stall request and range check
module data_sram_resp
  import data_sram_resp_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 12,
  parameter logic [63:0] BASE_ADDR  = DEFAULT_BASE_ADDR,
  parameter int          EXTRA_LAT  = 0
) (
  input logic              clk,
  input logic              rst,
  data_sram_resp_if.slave  bus
);
  localparam logic [2:0]  LAT_M1 = (EXTRA_LAT == 0) ? 3'd0 : 3'(EXTRA_LAT - 1);
  localparam logic [63:0] SPAN   = 64'(DWORD_BYTES) << DEPTH_LOG2;
  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        resp_q, resp_d, rd_q, rd_d, err_q, err_d;
  logic [63:0] hold_q, rdata_d, offset, ram_rdata;
  logic        accept, in_range, last;
  // Underflow for addresses below BASE_ADDR lands far above SPAN, so one compare covers both ends.
  assign offset   = bus.data_sram_addr - BASE_ADDR;
  assign in_range = offset < SPAN;
  assign accept   = state_q == IDLE && bus.data_sram_en;
  assign last     = state_q == WAIT && cnt_q == 3'd0;
  always_comb begin
    state_d = accept ? ((EXTRA_LAT == 0) ? IDLE : WAIT) : (last ? IDLE : state_q);
    cnt_d   = accept ? LAT_M1 : ((state_q == WAIT && !last) ? cnt_q - 3'd1 : cnt_q);
    resp_d  = (accept && EXTRA_LAT == 0) || last;
    rd_d    = accept ? bus.data_sram_we == '0 : rd_q;
    err_d   = accept ? !in_range : err_q;
    rdata_d = (resp_q && rd_q) ? (err_q ? '0 : ram_rdata) : hold_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      resp_q  <= 1'b0;
      rd_q    <= 1'b0;
      err_q   <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
      rd_q    <= rd_d;
      err_q   <= err_d;
      hold_q  <= rdata_d;
    end
  end
  // RAM read register stays frozen through WAIT since it is only enabled on acceptance.
  sram_be_64 #(.AW(DEPTH_LOG2)) u_ram (
    .clk     (clk),
    .en_i    (accept && in_range),
    .we_i    (bus.data_sram_we),
    .addr_i  (offset[DEPTH_LOG2+2:3]),
    .wdata_i (bus.data_sram_wdata),
    .rdata_o (ram_rdata)
  );
  assign bus.data_sram_rdata = rdata_d;
  assign bus.stallreq        = state_q == WAIT;
  assign bus.addr_err        = resp_q && err_q;
endmodule
